// File: rtl/uart_bus_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_bus_bridge_pkg
// Description : Command/reply codes, state encodings and widths for the
//               UART-to-bus bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_bus_bridge_pkg;

   localparam int c_TIMEOUT_W = 24;
   localparam int c_ADDR_W    = 30;
   localparam int c_DATA_W    = 32;

   localparam logic [7:0] c_CMD_WRITE = 8'h57;
   localparam logic [7:0] c_CMD_READ  = 8'h52;
   localparam logic [7:0] c_RPL_OK    = 8'h4B;
   localparam logic [7:0] c_RPL_ERR   = 8'h3F;

   typedef logic [2:0] state_t;

   localparam state_t c_ST_IDLE  = 3'd0;
   localparam state_t c_ST_ADDR  = 3'd1;
   localparam state_t c_ST_DATA  = 3'd2;
   localparam state_t c_ST_REQ   = 3'd3;
   localparam state_t c_ST_ACC   = 3'd4;
   localparam state_t c_ST_REPLY = 3'd5;

   function automatic logic is_cmd(input logic [7:0] b);
      return (b == c_CMD_WRITE) || (b == c_CMD_READ);
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : uart_bus_bridge
// Description : Bus master driven by UART command frames (W/R), replying
//               with 'K', read data, or '?' for unknown commands.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_bus_bridge
   import uart_bus_bridge_pkg::*;
#(
   parameter logic [c_TIMEOUT_W-1:0] TIMEOUT = 24'd1000000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                rx_end,
   input  logic [7:0]          rx_data,
   input  logic                tx_busy,
   output logic                tx_start,
   output logic [7:0]          tx_data,
   output logic                m_req_,
   input  logic                m_grnt_,
   output logic                m_as_,
   output logic                m_rw,
   output logic [c_ADDR_W-1:0] m_addr,
   output logic [c_DATA_W-1:0] m_wr_data,
   input  logic [c_DATA_W-1:0] m_rd_data,
   input  logic                m_rdy_
);

   state_t                   r_state;
   state_t                   w_next;
   logic                     r_rw;
   logic                     r_acc_first;
   logic                     r_err_pend;
   logic                     r_tx_start;
   logic [7:0]               r_tx_data;
   logic [1:0]               r_byte_cnt;
   logic [2:0]               r_reply_cnt;
   logic [c_TIMEOUT_W-1:0]   r_timer;
   logic [c_ADDR_W-1:0]      r_addr;
   logic [c_DATA_W-1:0]      r_wdata;
   logic [c_DATA_W-1:0]      r_reply_sh;

   logic                     w_byte_last;
   logic                     w_timeout;
   logic                     w_tx_ok;
   logic                     w_reply_go;
   logic                     w_err_go;

   assign w_byte_last = (r_byte_cnt == 2'd3);
   // Timer holds idle cycles since the last byte; abort when it would reach TIMEOUT.
   assign w_timeout   = (r_timer == TIMEOUT - c_TIMEOUT_W'(1)) && !rx_end;
   assign w_tx_ok     = !tx_busy && !r_tx_start;
   assign w_reply_go  = (r_state == c_ST_REPLY) && (r_reply_cnt != 3'd0) && w_tx_ok;
   assign w_err_go    = (r_state != c_ST_REPLY) && r_err_pend && w_tx_ok;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= c_ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         c_ST_IDLE: begin
            if (rx_end && is_cmd(rx_data)) w_next = c_ST_ADDR;
         end
         c_ST_ADDR: begin
            if (rx_end && w_byte_last) w_next = r_rw ? c_ST_REQ : c_ST_DATA;
            else if (w_timeout)        w_next = c_ST_IDLE;
         end
         c_ST_DATA: begin
            if (rx_end && w_byte_last) w_next = c_ST_REQ;
            else if (w_timeout)        w_next = c_ST_IDLE;
         end
         c_ST_REQ: begin
            if (!m_grnt_) w_next = c_ST_ACC;
         end
         c_ST_ACC: begin
            if (!m_rdy_) w_next = c_ST_REPLY;
         end
         c_ST_REPLY: begin
            if (w_reply_go && (r_reply_cnt == 3'd1)) w_next = c_ST_IDLE;
         end
         default: w_next = c_ST_IDLE;
      endcase
   end

   always_comb begin
      m_req_ = 1'b1;
      m_as_  = 1'b1;
      m_rw   = 1'b1;
      if ((r_state == c_ST_REQ) || (r_state == c_ST_ACC)) begin
         m_req_ = 1'b0;
         m_rw   = r_rw;
      end
      if ((r_state == c_ST_ACC) && r_acc_first) m_as_ = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rw        <= 1'b1;
         r_acc_first <= 1'b0;
         r_err_pend  <= 1'b0;
         r_tx_start  <= 1'b0;
         r_tx_data   <= 8'h00;
         r_byte_cnt  <= 2'd0;
         r_reply_cnt <= 3'd0;
         r_timer     <= '0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_reply_sh  <= '0;
      end else begin
         r_tx_start <= w_reply_go | w_err_go;
         if (w_reply_go)    r_tx_data <= r_reply_sh[31:24];
         else if (w_err_go) r_tx_data <= c_RPL_ERR;
         if (w_err_go) r_err_pend <= 1'b0;

         case (r_state)
            c_ST_IDLE: begin
               if (rx_end) begin
                  if (is_cmd(rx_data)) begin
                     r_rw       <= (rx_data == c_CMD_READ);
                     r_byte_cnt <= 2'd0;
                     r_timer    <= '0;
                  end else begin
                     r_err_pend <= 1'b1;
                  end
               end
            end
            c_ST_ADDR, c_ST_DATA: begin
               if (rx_end) begin
                  r_byte_cnt <= r_byte_cnt + 2'd1;
                  r_timer    <= '0;
                  if (r_state == c_ST_ADDR) r_addr  <= {r_addr[c_ADDR_W-9:0], rx_data};
                  else                      r_wdata <= {r_wdata[c_DATA_W-9:0], rx_data};
               end else if (w_timeout) begin
                  r_byte_cnt <= 2'd0;
                  r_timer    <= '0;
               end else begin
                  r_timer <= r_timer + c_TIMEOUT_W'(1);
               end
            end
            c_ST_REQ: begin
               if (!m_grnt_) r_acc_first <= 1'b1;
            end
            c_ST_ACC: begin
               r_acc_first <= 1'b0;
               if (!m_rdy_) begin
                  r_reply_sh  <= r_rw ? m_rd_data : {c_RPL_OK, 24'h000000};
                  r_reply_cnt <= r_rw ? 3'd4 : 3'd1;
               end
            end
            c_ST_REPLY: begin
               if (w_reply_go) begin
                  r_reply_sh  <= {r_reply_sh[23:0], 8'h00};
                  r_reply_cnt <= r_reply_cnt - 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign tx_start  = r_tx_start;
   assign tx_data   = r_tx_data;
   assign m_addr    = r_addr;
   assign m_wr_data = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_uart_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_bus_bridge
// Description : Self-checking bench: frame table, random frames against a
//               frame-level model, plus timeout / grant / reset corners.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_bus_bridge;

   localparam logic [23:0] TMO = 24'd16;

   logic        clk = 1'b0;
   logic        reset, rx_end, tx_busy, tx_start, m_req_, m_grnt_, m_as_, m_rw, m_rdy_;
   logic [7:0]  rx_data, tx_data;
   logic [29:0] m_addr;
   logic [31:0] m_wr_data, m_rd_data;

   always #5 clk = ~clk;

   uart_bus_bridge #(.TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset), .rx_end(rx_end), .rx_data(rx_data),
      .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
      .m_req_(m_req_), .m_grnt_(m_grnt_), .m_as_(m_as_), .m_rw(m_rw),
      .m_addr(m_addr), .m_wr_data(m_wr_data), .m_rd_data(m_rd_data), .m_rdy_(m_rdy_)
   );

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   // Frame record: frame bytes left-justified, expected bus transaction and reply.
   typedef struct packed {
      logic [71:0] frame;
      logic [3:0]  len;
      logic [31:0] rd;
      logic        txn;
      logic        rw;
      logic [29:0] addr;
      logic [31:0] wd;
      logic [2:0]  n;
      logic [31:0] r;
   } vec_t;

   function automatic vec_t mk(input logic [71:0] f, input logic [3:0] len, input logic [31:0] rd,
                               input logic txn, input logic rw, input logic [29:0] addr,
                               input logic [31:0] wd, input logic [2:0] n, input logic [31:0] r);
      vec_t v;
      v.frame = f; v.len = len; v.rd = rd; v.txn = txn; v.rw = rw;
      v.addr = addr; v.wd = wd; v.n = n; v.r = r;
      return v;
   endfunction

   // Frame-level reference: what a complete frame must do on the bus and UART.
   function automatic vec_t model(input logic [71:0] f, input logic [3:0] len, input logic [31:0] rd);
      if (f[71:64] == 8'h57 && len == 4'd9)
         return mk(f, len, rd, 1'b1, 1'b0, f[61:32], f[31:0], 3'd1, 32'h4B000000);
      else if (f[71:64] == 8'h52 && len == 4'd5)
         return mk(f, len, rd, 1'b1, 1'b1, f[61:32], 32'h0, 3'd4, rd);
      else
         return mk(f, len, rd, 1'b0, 1'b0, 30'h0, 32'h0, 3'd1, 32'h3F000000);
   endfunction

   // ---------------- UART transmitter model ----------------
   logic [7:0] tx_q[$];
   int         tx_busy_len = 2;

   initial begin
      int   busy_cnt;
      logic prev_start;
      tx_busy = 1'b0; busy_cnt = 0; prev_start = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (tx_start === 1'b1) begin
            check("tx_start_gap", {30'd0, tx_busy, prev_start}, 32'd0);
            tx_q.push_back(tx_data);
            busy_cnt = tx_busy_len;
         end else if (busy_cnt > 0) begin
            busy_cnt--;
         end
         prev_start = tx_start;
         tx_busy    = (busy_cnt != 0);
      end
   end

   // ---------------- bus slave / arbiter model ----------------
   int          grant_delay = 0;
   int          rdy_delay   = 0;
   int          n_txn       = 0;
   int          req_wait    = 0;
   logic [31:0] slave_rd    = 32'h0;
   logic        rec_rw;
   logic [29:0] rec_addr;
   logic [31:0] rec_wdata;

   initial begin
      int gcnt, rcnt;
      bit pend, g_seen, rdy_seen;
      m_grnt_ = 1'b1; m_rdy_ = 1'b1; m_rd_data = 32'h0;
      gcnt = 0; rcnt = 0; pend = 0;
      forever begin
         @(posedge clk); #1;
         g_seen   = (m_grnt_ == 1'b0);
         rdy_seen = (m_rdy_ == 1'b0);
         m_rdy_   = 1'b1;
         if (rdy_seen) check("req_release", 32'(m_req_), 32'd1);
         if (m_req_ === 1'b1) pend = 0;
         if (m_as_ === 1'b0) begin
            check("as_after_grant", 32'(g_seen), 32'd1);
            n_txn++;
            rec_rw = m_rw; rec_addr = m_addr; rec_wdata = m_wr_data;
            m_rd_data = slave_rd; req_wait = gcnt;
            pend = 1; rcnt = rdy_delay;
         end else if (pend) begin
            check("hold_addr", 32'(m_addr), 32'(rec_addr));
            check("hold_rw", 32'(m_rw), 32'(rec_rw));
            check("hold_wdata", m_wr_data, rec_wdata);
         end
         if (pend) begin
            if (rcnt == 0) begin m_rdy_ = 1'b0; pend = 0; end
            else rcnt--;
         end
         if (m_req_ === 1'b0) begin
            if (gcnt < grant_delay) begin gcnt++; m_grnt_ = 1'b1; end
            else m_grnt_ = 1'b0;
         end else begin
            gcnt = 0; m_grnt_ = 1'b1;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send_byte(input logic [7:0] b, input int gap);
      rx_data = b; rx_end = 1'b1;
      @(posedge clk); #1;
      rx_end = 1'b0; rx_data = 8'($urandom);
      repeat (gap) begin @(posedge clk); #1; end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic run_vec(input vec_t v, input string tag, input int gap);
      int txn0, cyc;
      txn0 = n_txn;
      tx_q.delete();
      slave_rd = v.rd;
      for (int i = 0; i < int'(v.len); i++)
         send_byte(v.frame[71-8*i -: 8], (gap < 0) ? $urandom_range(0, 3) : gap);
      cyc = 0;
      while (tx_q.size() < int'(v.n) && cyc < 2000) begin @(posedge clk); #1; cyc++; end
      wait_cycles(10);
      check({tag, "_nreply"}, 32'(tx_q.size()), 32'(v.n));
      for (int i = 0; i < int'(v.n); i++)
         if (i < tx_q.size()) check({tag, "_reply"}, 32'(tx_q[i]), 32'(v.r[31-8*i -: 8]));
      check({tag, "_ntxn"}, 32'(n_txn - txn0), 32'(v.txn));
      if (v.txn) begin
         check({tag, "_rw"}, 32'(rec_rw), 32'(v.rw));
         check({tag, "_addr"}, 32'(rec_addr), 32'(v.addr));
         if (!v.rw) check({tag, "_wdata"}, rec_wdata, v.wd);
      end
   endtask

   vec_t tbl[6];

   initial begin
      int txn0, cnt, kind;
      logic [7:0] b;

      tbl[0] = mk({8'h57, 32'h00000010, 32'hDEADBEEF}, 4'd9, 32'h0,
                  1'b1, 1'b0, 30'h10, 32'hDEADBEEF, 3'd1, 32'h4B000000);
      tbl[1] = mk({8'h52, 32'h00000020, 32'h0}, 4'd5, 32'h12345678,
                  1'b1, 1'b1, 30'h20, 32'h0, 3'd4, 32'h12345678);
      tbl[2] = mk({8'h41, 64'h0}, 4'd1, 32'h0, 1'b0, 1'b0, 30'h0, 32'h0, 3'd1, 32'h3F000000);
      tbl[3] = mk({8'h57, 32'hFFFFFFFC, 32'h01020304}, 4'd9, 32'h0,
                  1'b1, 1'b0, 30'h3FFFFFFC, 32'h01020304, 3'd1, 32'h4B000000);
      tbl[4] = mk({8'h52, 32'hC0000001, 32'h0}, 4'd5, 32'hA5A50F0F,
                  1'b1, 1'b1, 30'h1, 32'h0, 3'd4, 32'hA5A50F0F);
      tbl[5] = mk({8'h00, 64'h0}, 4'd1, 32'h0, 1'b0, 1'b0, 30'h0, 32'h0, 3'd1, 32'h3F000000);

      reset = 1'b1; rx_end = 1'b0; rx_data = 8'h00;
      wait_cycles(3);
      check("rst_req", 32'(m_req_), 32'd1);
      check("rst_as", 32'(m_as_), 32'd1);
      check("rst_rw", 32'(m_rw), 32'd1);
      check("rst_addr", 32'(m_addr), 32'd0);
      check("rst_wdata", m_wr_data, 32'd0);
      check("rst_txstart", 32'(tx_start), 32'd0);
      check("rst_txdata", 32'(tx_data), 32'd0);
      reset = 1'b0;
      wait_cycles(2);

      for (int i = 0; i < 6; i++) begin
         grant_delay = $urandom_range(0, 3);
         rdy_delay   = $urandom_range(0, 3);
         tx_busy_len = $urandom_range(0, 3);
         run_vec(tbl[i], $sformatf("tbl%0d", i), -1);
      end

      for (int i = 0; i < 24; i++) begin
         grant_delay = $urandom_range(0, 4);
         rdy_delay   = $urandom_range(0, 4);
         tx_busy_len = $urandom_range(0, 3);
         kind = $urandom_range(0, 2);
         if (kind == 0)
            run_vec(model({8'h57, 32'($urandom), 32'($urandom)}, 4'd9, 32'h0), "rnd_w", -1);
         else if (kind == 1)
            run_vec(model({8'h52, 32'($urandom), 32'h0}, 4'd5, 32'($urandom)), "rnd_r", -1);
         else begin
            b = 8'($urandom);
            while (b == 8'h57 || b == 8'h52) b = 8'($urandom);
            run_vec(model({b, 64'h0}, 4'd1, 32'h0), "rnd_x", -1);
         end
      end

      // Abandoned frame: two address bytes then silence longer than TIMEOUT.
      grant_delay = 0; rdy_delay = 1; tx_busy_len = 2;
      tx_q.delete(); txn0 = n_txn; cnt = 0;
      send_byte(8'h57, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
      for (int i = 0; i < 30; i++) begin
         if (m_req_ !== 1'b1) cnt++;
         @(posedge clk); #1;
      end
      check("tmo_req_low_cycles", 32'(cnt), 32'd0);
      check("tmo_ntxn", 32'(n_txn - txn0), 32'd0);
      check("tmo_nreply", 32'(tx_q.size()), 32'd0);
      run_vec(model({8'h52, 32'h00000100, 32'h0}, 4'd5, 32'hCAFEF00D), "tmo_next", -1);

      // Gaps well inside TIMEOUT must not abandon the frame.
      run_vec(model({8'h57, 32'h00000ABC, 32'h11223344}, 4'd9, 32'h0), "slow_w", 10);

      // Grant withheld for 50 cycles.
      grant_delay = 50;
      run_vec(model({8'h57, 32'h00000040, 32'h55AA55AA}, 4'd9, 32'h0), "gnt_w", -1);
      check("gnt_wait", 32'(req_wait >= 50), 32'd1);
      grant_delay = 0;

      // Reset while the access is outstanding.
      rdy_delay = 30;
      tx_q.delete(); txn0 = n_txn; slave_rd = 32'h87654321;
      for (int i = 0; i < 5; i++) send_byte((i == 0) ? 8'h52 : ((i == 4) ? 8'h44 : 8'h00), 0);
      cnt = 0;
      while (n_txn == txn0 && cnt < 100) begin @(posedge clk); #1; cnt++; end
      check("racc_started", 32'(n_txn - txn0), 32'd1);
      wait_cycles(1);
      reset = 1'b1;
      @(posedge clk); #1;
      check("racc_req", 32'(m_req_), 32'd1);
      check("racc_as", 32'(m_as_), 32'd1);
      reset = 1'b0;
      wait_cycles(40);
      check("racc_nreply", 32'(tx_q.size()), 32'd0);
      rdy_delay = 0;
      run_vec(model({8'h52, 32'h00000008, 32'h0}, 4'd5, 32'h0BADCAFE), "racc_next", -1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_bus_bridge.md
UART_BUS_BRIDGE -- requirements
Module: uart_bus_bridge

Interface
REQ-001 Parameter: TIMEOUT, default 24'd1000000, cycles allowed between frame bytes before the frame is abandoned.
REQ-002 Port: clk  in  1  system clock; the single clock for all logic.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: rx_end  in  1  one-cycle pulse; rx_data holds a valid received byte.
REQ-005 Port: rx_data  in  8  received byte from uart_rx.
REQ-006 Port: tx_busy  in  1  uart_tx is transmitting.
REQ-007 Port: tx_start  out  1  one-cycle pulse that launches tx_data.
REQ-008 Port: tx_data  out  8  byte to transmit.
REQ-009 Port: m_req_  out  1  bus request, active-low.
REQ-010 Port: m_grnt_  in  1  bus grant, active-low.
REQ-011 Port: m_as_  out  1  address strobe, active-low.
REQ-012 Port: m_rw  out  1  1=read, 0=write.
REQ-013 Port: m_addr  out  30  word address.
REQ-014 Port: m_wr_data  out  32  write data.
REQ-015 Port: m_rd_data  in  32  read data.
REQ-016 Port: m_rdy_  in  1  access complete, active-low.

Function
REQ-017 The block SHALL act as bus master that executes commands received as UART byte frames; it is the initiator for the bus slaves, including uart.
REQ-018 Frames SHALL be: 'W'(0x57), 4 address bytes, 4 data bytes; or 'R'(0x52), 4 address bytes. Multi-byte fields are MSB first. m_addr = low 30 bits of the address field.
REQ-019 State machine states SHALL be IDLE, ADDR, DATA, REQ, ACC, REPLY, with the following transitions:
- IDLE -> ADDR on a 'W'/'R' byte.
- ADDR -> DATA after the 4th address byte for W; ADDR -> REQ after the 4th address byte for R.
- DATA -> REQ after the 4th data byte.
- REQ -> ACC when m_grnt_=0.
- ACC -> REPLY when m_rdy_=0.
- REPLY -> IDLE after the last reply byte is launched.
REQ-020 Any other command byte received in IDLE SHALL queue a single reply 0x3F ('?') and remain in protocol IDLE; no bus access occurs.
REQ-021 Bus handshake:
- In REQ, m_req_=0 SHALL be held.
- In the first ACC cycle, m_as_=0 SHALL be asserted for exactly one cycle, with m_addr/m_rw/m_wr_data valid.
- m_addr/m_rw/m_wr_data SHALL be held until m_rdy_=0.
- m_req_ SHALL be held low through ACC and released the cycle after m_rdy_=0.
REQ-022 A read SHALL capture m_rd_data in the cycle m_rdy_=0.
REQ-023 Replies:
- Write: one byte 0x4B ('K').
- Read: 4 data bytes, MSB first.
REQ-024 tx_start SHALL pulse only when tx_busy=0 and no tx_start was issued in the previous cycle; there is one byte per pulse.
REQ-025 rx_end bytes arriving in REQ/ACC/REPLY SHALL be discarded.
REQ-026 An inter-byte counter SHALL reset on each rx_end in ADDR/DATA. On reaching TIMEOUT, the state SHALL return to IDLE with no bus access and no reply.
REQ-027 A byte counter (2 bits) SHALL wrap 3->0 at the field boundary. The shift registers SHALL shift left 8 per byte.
REQ-028 Idle outputs SHALL be: m_req_=1, m_as_=1, m_rw=1, tx_start=0.

Reset
REQ-029 On reset=1 at a clk edge, the block SHALL enter IDLE with:
- m_req_=1, m_as_=1, m_rw=1.
- m_addr=0, m_wr_data=0.
- tx_start=0, tx_data=0.
- Counters cleared.
REQ-030 Reset mid-access SHALL abort immediately. No reply SHALL be sent, and the bus SHALL be released in the next cycle.

Structure
REQ-031 Command codes, reply codes, state encodings and the TIMEOUT width SHALL reside in the shared header uart_bus_bridge.h. Bus widths SHALL come from the global headers.
REQ-032 The block SHALL be a single module with no sub-modules. It SHALL be instantiated beside uart_rx/uart_tx in a top-level debug wrapper.

Verification
REQ-033 W,00,00,00,10,DE,AD,BE,EF -> one m_as_ pulse with m_addr=0x10, m_rw=0, m_wr_data=0xDEADBEEF; after m_rdy_=0, reply 0x4B.
REQ-034 R,00,00,00,20 with the slave returning 0x12345678 -> m_rw=1, m_addr=0x20; reply 12,34,56,78 in order, each tx_start only while tx_busy=0.
REQ-035 Byte 0x41 in IDLE -> reply 0x3F; m_req_ stays 1.
REQ-036 W with only 2 address bytes, then silence for TIMEOUT=16 cycles -> IDLE, no bus activity; a following full R frame executes correctly.
REQ-037 m_grnt_ withheld for 50 cycles -> m_req_=0 held and m_as_=1 until grant; m_as_ then pulses once.
REQ-038 reset asserted during ACC -> next cycle m_req_=1, m_as_=1, no reply byte.
